// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - single-channel synchronizer, stability counter and edge strobes
module debounce_channel #(
  parameter int BITS = 20,
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  logic            s;
  logic [BITS-1:0] count;

  generate
    if (SYNC) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], in};
      end
      assign s = sync_q[1];
    end else begin : g_nosync
      assign s = in;
    end
  endgenerate

  // A level is accepted on the cycle after the counter saturates, so s must
  // differ from out for 2^BITS consecutive samples; any agreeing sample restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == out) begin
        count <= '0;
      end else if (!(&count)) begin
        count <= count + BITS'(1);
      end else begin
        out   <= s;
        count <= '0;
        rise  <= s;
        fall  <= ~s;
      end
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - multi-channel debouncer, one independent channel per input bit
module input_debouncer #(
  parameter int WIDTH = 1,
  parameter int BITS  = 20,
  parameter bit SYNC  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
        .BITS (BITS),
        .SYNC (SYNC)
      ) u_ch (
        .clk   (clk),
        .reset (reset),
        .in    (in[i]),
        .out   (out[i]),
        .rise  (rise[i]),
        .fall  (fall[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench for input_debouncer
module tb_input_debouncer;

  typedef struct {
    int         cyc;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] in_a = 2'b00;
  logic [1:0] out_a, rise_a, fall_a;
  logic [0:0] in_b = 1'b0;
  logic [0:0] out_b, rise_b, fall_b;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  input_debouncer #(.WIDTH(2), .BITS(3), .SYNC(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a)
  );

  input_debouncer #(.WIDTH(1), .BITS(1), .SYNC(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset();
    int   base;
    exp_t e;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_a, rise_a, fall_a, out_b, rise_b, fall_b} !== 9'b0) begin
      errors++;
      $display("FAIL reset_hold: a=%b/%b/%b b=%b/%b/%b, need all 0", out_a, rise_a, fall_a, out_b, rise_b, fall_b);
    end
    reset = 1'b0;
    base = cyc;
    q_a.push_back('{base + 1, 2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 2, 2'b00, 2'b00, 2'b00});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      while (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
        e = q_a.pop_front();
        checks++;
        if (e.cyc != cyc || out_a !== e.out || rise_a !== e.rise || fall_a !== e.fall) begin
          errors++;
          $display("FAIL reset_release cyc=%0d: out=%b rise=%b fall=%b, need out=%b rise=%b fall=%b @%0d",
                   cyc, out_a, rise_a, fall_a, e.out, e.rise, e.fall, e.cyc);
        end
      end
    end
  endtask

  task automatic test_rise();
    int   base;
    exp_t e;
    base = cyc;
    in_a = 2'b01;
    q_a.push_back('{base + 9,  2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 10, 2'b01, 2'b01, 2'b00});
    q_a.push_back('{base + 11, 2'b01, 2'b00, 2'b00});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      while (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
        e = q_a.pop_front();
        checks++;
        if (e.cyc != cyc || out_a !== e.out || rise_a !== e.rise || fall_a !== e.fall) begin
          errors++;
          $display("FAIL rise cyc=%0d: out=%b rise=%b fall=%b, need out=%b rise=%b fall=%b @%0d",
                   cyc, out_a, rise_a, fall_a, e.out, e.rise, e.fall, e.cyc);
        end
      end
    end
  endtask

  task automatic test_fall();
    int   base;
    exp_t e;
    base = cyc;
    in_a = 2'b00;
    q_a.push_back('{base + 9,  2'b01, 2'b00, 2'b00});
    q_a.push_back('{base + 10, 2'b00, 2'b00, 2'b01});
    q_a.push_back('{base + 11, 2'b00, 2'b00, 2'b00});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      while (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
        e = q_a.pop_front();
        checks++;
        if (e.cyc != cyc || out_a !== e.out || rise_a !== e.rise || fall_a !== e.fall) begin
          errors++;
          $display("FAIL fall cyc=%0d: out=%b rise=%b fall=%b, need out=%b rise=%b fall=%b @%0d",
                   cyc, out_a, rise_a, fall_a, e.out, e.rise, e.fall, e.cyc);
        end
      end
    end
  endtask

  // 7-cycle pulse is dropped; 8-cycle pulse is accepted and later falls back.
  task automatic test_pulse_width();
    int   base;
    exp_t e;
    base = cyc;
    q_a.push_back('{base + 9,  2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 10, 2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 11, 2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 19, 2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 20, 2'b01, 2'b01, 2'b00});
    q_a.push_back('{base + 21, 2'b01, 2'b00, 2'b00});
    q_a.push_back('{base + 28, 2'b00, 2'b00, 2'b01});
    q_a.push_back('{base + 29, 2'b00, 2'b00, 2'b00});
    for (int i = 0; i < 30; i++) begin
      in_a = ((i < 7) || (i >= 10 && i < 18)) ? 2'b01 : 2'b00;
      @(negedge clk);
      while (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
        e = q_a.pop_front();
        checks++;
        if (e.cyc != cyc || out_a !== e.out || rise_a !== e.rise || fall_a !== e.fall) begin
          errors++;
          $display("FAIL pulse_width cyc=%0d: out=%b rise=%b fall=%b, need out=%b rise=%b fall=%b @%0d",
                   cyc, out_a, rise_a, fall_a, e.out, e.rise, e.fall, e.cyc);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int   base;
    exp_t e;
    base = cyc;
    q_a.push_back('{base + 15, 2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 16, 2'b01, 2'b01, 2'b00});
    q_a.push_back('{base + 17, 2'b01, 2'b00, 2'b00});
    q_a.push_back('{base + 28, 2'b00, 2'b00, 2'b01});
    for (int i = 0; i < 30; i++) begin
      in_a = (i == 5 || i >= 18) ? 2'b00 : 2'b01;
      @(negedge clk);
      while (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
        e = q_a.pop_front();
        checks++;
        if (e.cyc != cyc || out_a !== e.out || rise_a !== e.rise || fall_a !== e.fall) begin
          errors++;
          $display("FAIL bounce cyc=%0d: out=%b rise=%b fall=%b, need out=%b rise=%b fall=%b @%0d",
                   cyc, out_a, rise_a, fall_a, e.out, e.rise, e.fall, e.cyc);
        end
      end
    end
  endtask

  // Both channels together, then reset mid-strobe and again mid-count.
  task automatic test_simultaneous_reset();
    int   base;
    exp_t e;
    base = cyc;
    in_a = 2'b11;
    q_a.push_back('{base + 9,  2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 10, 2'b11, 2'b11, 2'b00});
    q_a.push_back('{base + 21, 2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 26, 2'b00, 2'b00, 2'b00});
    q_a.push_back('{base + 27, 2'b11, 2'b11, 2'b00});
    q_a.push_back('{base + 28, 2'b11, 2'b00, 2'b00});
    for (int i = 0; i < 30; i++) begin
      if (i == 10 || i == 16) begin
        reset = 1'b1;
        #1;
        checks++;
        if ({out_a, rise_a, fall_a} !== 6'b0) begin
          errors++;
          $display("FAIL reset_async i=%0d: out=%b rise=%b fall=%b, need all 0", i, out_a, rise_a, fall_a);
        end
      end
      if (i == 11 || i == 17) reset = 1'b0;
      @(negedge clk);
      while (q_a.size() != 0 && q_a[0].cyc <= cyc) begin
        e = q_a.pop_front();
        checks++;
        if (e.cyc != cyc || out_a !== e.out || rise_a !== e.rise || fall_a !== e.fall) begin
          errors++;
          $display("FAIL simultaneous cyc=%0d: out=%b rise=%b fall=%b, need out=%b rise=%b fall=%b @%0d",
                   cyc, out_a, rise_a, fall_a, e.out, e.rise, e.fall, e.cyc);
        end
      end
    end
  endtask

  task automatic test_nosync();
    int   base;
    exp_t e;
    base = cyc;
    q_b.push_back('{base + 1,  2'b00, 2'b00, 2'b00});
    q_b.push_back('{base + 2,  2'b01, 2'b01, 2'b00});
    q_b.push_back('{base + 3,  2'b01, 2'b00, 2'b00});
    q_b.push_back('{base + 7,  2'b01, 2'b00, 2'b00});
    q_b.push_back('{base + 8,  2'b01, 2'b00, 2'b00});
    q_b.push_back('{base + 12, 2'b00, 2'b00, 2'b01});
    q_b.push_back('{base + 17, 2'b00, 2'b00, 2'b00});
    q_b.push_back('{base + 18, 2'b00, 2'b00, 2'b00});
    for (int i = 0; i < 20; i++) begin
      in_b = ((i < 10 && i != 5) || i == 15) ? 1'b1 : 1'b0;
      @(negedge clk);
      while (q_b.size() != 0 && q_b[0].cyc <= cyc) begin
        e = q_b.pop_front();
        checks++;
        if (e.cyc != cyc || {1'b0, out_b} !== e.out || {1'b0, rise_b} !== e.rise || {1'b0, fall_b} !== e.fall) begin
          errors++;
          $display("FAIL nosync cyc=%0d: out=%b rise=%b fall=%b, need out=%b rise=%b fall=%b @%0d",
                   cyc, out_b, rise_b, fall_b, e.out[0], e.rise[0], e.fall[0], e.cyc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_fall();
    test_pulse_width();
    test_bounce();
    test_simultaneous_reset();
    test_nosync();
    checks++;
    if (q_a.size() + q_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", q_a.size() + q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
